ad_ip_jesd204_tpl_dac_pngen: RTL and testbench

// - Transmit-side PN9/PN23 test pattern generator for the JESD204 DAC transport layer, one instance per converter.
// - Produces DATA_PATH_WIDTH samples per clock in converter order, with optional offset-binary mapping.
// - Output is bit-exact with what the TPL ADC PN monitor expects, so DAC->ADC loopback locks it.
// - Gated enable, sequence-change reseed and single-bit error injection support link bring-up and monitor verification.

---
 rtl/ad_ip_jesd204_tpl_dac_pngen.sv | 131 +++++++++++++
 tb/tb_ad_ip_jesd204_tpl_dac_pngen.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_dac_pngen.sv
// ---------------------------------------------------------------------------
// ad_ip_jesd204_tpl_dac_pngen
//
// Transmit-side PN9 / PN23 test pattern generator for one converter of the
// JESD204 DAC transport layer. Each clock it produces DATA_PATH_WIDTH samples
// of CONVERTER_RESOLUTION bits. The output is bit-exact with the TPL ADC PN
// monitor, so a DAC->ADC loopback locks onto it.
//
// Ports
//   clk            in   core clock
//   reset          in   synchronous, active-high
//   enable         in   1: generate words; 0: freeze sequence, output zero
//   pn_seq_sel     in   4'h0 selects PN9, any other value selects PN23
//   pn_err_inject  in   one-cycle pulse; flips bit 0 of the word emitted
//                       on the same edge (only while running)
//   data           out  sample i at [i*CR +: CR], sample 0 oldest in time
//   data_valid     out  1 when data carries a PN word
// ---------------------------------------------------------------------------
module ad_ip_jesd204_tpl_dac_pngen #(
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int DATA_PATH_WIDTH      = 1,
    parameter int TWOS_COMPLEMENT      = 1
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            enable,
    input  logic [3:0]                                      pn_seq_sel,
    input  logic                                            pn_err_inject,
    output logic [CONVERTER_RESOLUTION*DATA_PATH_WIDTH-1:0] data,
    output logic                                            data_valid
);

    localparam int CR   = CONVERTER_RESOLUTION;
    localparam int DPW  = DATA_PATH_WIDTH;
    localparam int N    = CR * DPW;
    // State must cover the longest tap (23) and a full word.
    localparam int PN_W = (N > 23) ? N : 23;

    // Offset-binary mapping: invert each sample's MSB.
    localparam logic [CR-1:0] MSB_MASK =
        (TWOS_COMPLEMENT != 0) ? {1'b1, {(CR-1){1'b0}}} : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESEED = 2'd2
    } state_e;

    state_e            fsm_q, fsm_d;
    logic [PN_W-1:0]   pn_q, pn_d;
    logic [3:0]        sel_q;
    logic [N-1:0]      data_q, data_d;
    logic              valid_q, valid_d;

    logic [N-1:0]      w;
    logic [N-1:0]      sw;
    logic [PN_W+N-1:0] cat;
    logic [PN_W-1:0]   pn_next;
    logic              seq_chg;

    // Parallel LFSR step: bits are resolved from the oldest (MSB) down, so
    // each new bit only depends on state or on bits already computed.
    function automatic logic [N-1:0] pn_word(input logic [PN_W-1:0] st,
                                             input logic            pn23);
        logic [PN_W+N-1:0] full;
        full          = '0;
        full[PN_W+N-1:N] = st;
        for (int j = N - 1; j >= 0; j--) begin
            if (pn23) full[j] = full[j+23] ^ full[j+18];
            else      full[j] = full[j+9]  ^ full[j+5];
        end
        return full[N-1:0];
    endfunction

    assign w       = pn_word(pn_q, sel_q != 4'h0);
    assign cat     = {pn_q, w};
    assign pn_next = cat[PN_W-1:0];
    assign seq_chg = (pn_seq_sel != sel_q);

    // Oldest sample of the word (top CR bits of w) goes to sample slot 0.
    for (genvar i = 0; i < DPW; i++) begin : g_swz
        assign sw[i*CR +: CR] = w[(DPW-1-i)*CR +: CR] ^ MSB_MASK;
    end

    always_comb begin
        fsm_d   = fsm_q;
        pn_d    = pn_q;
        data_d  = '0;
        valid_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (seq_chg)     fsm_d = RESEED;
                else if (enable) fsm_d = RUN;
            end
            RUN: begin
                // The word for this edge is emitted regardless of the
                // transition; the sequence only advances when a word leaves.
                data_d  = sw ^ {{(N-1){1'b0}}, pn_err_inject};
                valid_d = 1'b1;
                pn_d    = pn_next;
                if (seq_chg)      fsm_d = RESEED;
                else if (!enable) fsm_d = IDLE;
            end
            RESEED: begin
                pn_d  = '1;
                fsm_d = enable ? RUN : IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q   <= IDLE;
            pn_q    <= '1;
            sel_q   <= 4'h0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pn_q    <= pn_d;
            sel_q   <= pn_seq_sel;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data       = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_pngen.sv
module tb_ad_ip_jesd204_tpl_dac_pngen;

    localparam int N = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic [3:0]   pn_seq_sel = 4'h0;
    logic         pn_err_inject = 1'b0;
    logic [N-1:0] data;
    logic         data_valid;

    ad_ip_jesd204_tpl_dac_pngen #(
        .CONVERTER_RESOLUTION(16),
        .DATA_PATH_WIDTH(1),
        .TWOS_COMPLEMENT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .pn_seq_sel(pn_seq_sel),
        .pn_err_inject(pn_err_inject),
        .data(data),
        .data_valid(data_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [N-1:0] d;
        string        tag;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Serial reference LFSR: one bit per step, newest bit at h[0].
    logic [22:0] h   = '1;
    logic        m23 = 1'b0;

    task automatic model_word(output logic [N-1:0] wd);
        logic nb;
        for (int b = N - 1; b >= 0; b--) begin
            nb = m23 ? (h[22] ^ h[17]) : (h[8] ^ h[4]);
            h  = {h[21:0], nb};
            wd[b] = nb;
        end
    endtask

    task automatic reseed_model(input logic pn23);
        m23 = pn23;
        h   = '1;
    endtask

    task automatic apply(input logic r, input logic e, input logic [3:0] s,
                         input logic inj);
        @(negedge clk);
        reset         = r;
        enable        = e;
        pn_seq_sel    = s;
        pn_err_inject = inj;
    endtask

    // Cycle whose output is expected to be idle (zero, not valid).
    task automatic cyc_zero(input logic r, input logic e, input logic [3:0] s,
                            input logic inj, input string tag);
        exp_t x;
        apply(r, e, s, inj);
        x.v = 1'b0; x.d = '0; x.tag = tag;
        q.push_back(x);
    endtask

    // Cycle whose output is the next model word (MSB inverted, bit0 ^ inj).
    task automatic cyc_word(input logic e, input logic [3:0] s,
                            input logic inj, input string tag);
        exp_t         x;
        logic [N-1:0] wd;
        apply(1'b0, e, s, inj);
        model_word(wd);
        x.v = 1'b1; x.d = wd ^ 16'h8000 ^ {15'd0, inj}; x.tag = tag;
        q.push_back(x);
    endtask

    // Cycle whose output is the hand-computed first PN9 word after seeding.
    task automatic cyc_first_pn9(input string tag);
        exp_t         x;
        logic [N-1:0] wd;
        apply(1'b0, 1'b1, 4'h0, 1'b0);
        model_word(wd);   // keep the model in step
        x.v = 1'b1; x.d = 16'h87BE; x.tag = tag;
        q.push_back(x);
    endtask

    // Monitor: one expectation per registered output, sampled 2ns after edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                n_chk++;
                if (data_valid === x.v && data === x.d)
                    n_pass++;
                else
                    $display("FAIL %s: got valid=%b data=%h, expected valid=%b data=%h",
                             x.tag, data_valid, data, x.v, x.d);
            end
        end
    end

    initial begin
        int budget;

        // Reset state.
        cyc_zero(1, 0, 4'h0, 0, "reset0");
        cyc_zero(1, 0, 4'h0, 0, "reset1");

        // Enable: RUN entered at this edge, first word one edge later.
        cyc_zero(0, 1, 4'h0, 0, "enable_edge");
        cyc_first_pn9("first_word");
        for (int i = 0; i < 4; i++) cyc_word(1, 4'h0, 0, "pn9");

        // Error injection: single, then back-to-back.
        cyc_word(1, 4'h0, 1, "inject1");
        cyc_word(1, 4'h0, 0, "post_inject");
        cyc_word(1, 4'h0, 1, "b2b_inject_a");
        cyc_word(1, 4'h0, 1, "b2b_inject_b");
        cyc_word(1, 4'h0, 0, "post_b2b");

        // Enable low for 5 cycles; inject during IDLE must be ignored.
        cyc_word(0, 4'h0, 0, "gap_last_word");
        cyc_zero(0, 0, 4'h0, 0, "gap");
        cyc_zero(0, 0, 4'h0, 1, "gap_inject_ignored");
        cyc_zero(0, 0, 4'h0, 0, "gap");
        cyc_zero(0, 0, 4'h0, 0, "gap");
        cyc_zero(0, 1, 4'h0, 0, "gap_reenable");
        for (int i = 0; i < 5; i++) cyc_word(1, 4'h0, 0, "resume");

        // Sequence change PN9 -> PN23 while running.
        cyc_word(1, 4'h1, 0, "chg_last_pn9");
        reseed_model(1'b1);
        cyc_zero(0, 1, 4'h1, 0, "reseed");
        for (int i = 0; i < 6; i++) cyc_word(1, 4'h1, 0, "pn23");

        // Reset mid-run, selecting PN9 again.
        cyc_zero(1, 1, 4'h0, 0, "mid_reset");
        reseed_model(1'b0);
        cyc_zero(0, 1, 4'h0, 0, "post_reset_idle");
        cyc_first_pn9("post_reset_first");
        for (int i = 0; i < 2; i++) cyc_word(1, 4'h0, 0, "post_reset_pn9");

        // Reset with PN23 held: registered select clears, so a reseed follows.
        cyc_zero(1, 1, 4'h1, 0, "reset_sel23");
        cyc_zero(0, 1, 4'h1, 0, "reset_sel_change");
        cyc_zero(0, 1, 4'h1, 0, "reset_sel_reseed");
        reseed_model(1'b1);
        for (int i = 0; i < 3; i++) cyc_word(1, 4'h1, 0, "pn23_after_reset");

        // Disable to finish.
        cyc_word(0, 4'h1, 0, "final_word");
        cyc_zero(0, 0, 4'h1, 0, "final_idle");

        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
